// File: rtl/mdp3_book_engine_if.sv
// Update bus between MDP3_Parser and mdp3_book_engine.
//   master (parser): drives message_ready and the decoded update fields,
//                    observes orderbook_ready.
//   slave  (engine): the reverse.
// Field names keep the parser's uppercase naming.
interface mdp3_book_engine_if #(
  parameter int unsigned PRICE_W = 64,
  parameter int unsigned QTY_W   = 16,
  parameter int unsigned NORD_W  = 8
);
  logic               message_ready;
  logic [31:0]        SECURITY_ID;
  logic [1:0]         ACTION;
  logic [1:0]         ENTRY_TYPE;
  logic [7:0]         PRICE_LEVEL;
  logic [PRICE_W-1:0] PRICE;
  logic [QTY_W-1:0]   QUANTITY;
  logic [NORD_W-1:0]  NUM_ORDERS;
  logic               orderbook_ready;

  modport master (
    output message_ready, SECURITY_ID, ACTION, ENTRY_TYPE, PRICE_LEVEL,
           PRICE, QUANTITY, NUM_ORDERS,
    input  orderbook_ready
  );

  modport slave (
    input  message_ready, SECURITY_ID, ACTION, ENTRY_TYPE, PRICE_LEVEL,
           PRICE, QUANTITY, NUM_ORDERS,
    output orderbook_ready
  );
endinterface

// File: rtl/mdp3_book_engine.sv
// Market-by-price book engine for one security: DEPTH-level bid/ask books
// maintained from decoded MDP3 updates (New/Change/Delete/ClearSide).
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   upd                 update bus (slave side), orderbook_ready = IDLE
//   bid_book/ask_book   level i at [i*LW +: LW], {price,qty,norders}, 0 = best
//   bid_count/ask_count occupied levels per side
//   book_updated        1-cycle pulse after an applied update
//   tob_changed         with book_updated when level 0 of the side changed
//   level_error         1-cycle pulse for an illegal level/action
module mdp3_book_engine #(
  parameter logic [31:0] SEC_ID  = 32'd123,
  parameter int unsigned DEPTH   = 10,
  parameter int unsigned PRICE_W = 64,
  parameter int unsigned QTY_W   = 16,
  parameter int unsigned NORD_W  = 8,
  localparam int unsigned LW = PRICE_W + QTY_W + NORD_W,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mdp3_book_engine_if.slave     upd,
  output logic [DEPTH*LW-1:0]   bid_book,
  output logic [DEPTH*LW-1:0]   ask_book,
  output logic [CW-1:0]         bid_count,
  output logic [CW-1:0]         ask_count,
  output logic                  book_updated,
  output logic                  tob_changed,
  output logic                  level_error
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] APPLY   = 2'd1;
  localparam logic [1:0] PUBLISH = 2'd2;

  localparam logic [1:0] A_NEW = 2'd0;
  localparam logic [1:0] A_CHG = 2'd1;
  localparam logic [1:0] A_DEL = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] bid_q [DEPTH];
  logic [LW-1:0] bid_d [DEPTH];
  logic [LW-1:0] ask_q [DEPTH];
  logic [LW-1:0] ask_d [DEPTH];
  logic [CW-1:0] bid_cnt_q, bid_cnt_d, ask_cnt_q, ask_cnt_d;
  logic [1:0]    act_q, act_d;
  logic          side_q, side_d;
  logic [7:0]    lvl_q, lvl_d;
  logic [LW-1:0] ent_q, ent_d;
  logic          err_q, err_d, tob_q, tob_d;
  logic          rdy_q, rdy_d, upd_q, upd_d, tobp_q, tobp_d, lerr_q, lerr_d;

  // Working copy of the addressed side during APPLY
  logic [LW-1:0] cur [DEPTH];
  logic [LW-1:0] nb  [DEPTH];
  logic [CW-1:0] n, nn;
  logic          legal;
  int            lm1;

  // Next-state, book edit and output logic
  always_comb begin
    state_d   = state_q;
    bid_d     = bid_q;
    ask_d     = ask_q;
    bid_cnt_d = bid_cnt_q;
    ask_cnt_d = ask_cnt_q;
    act_d     = act_q;
    side_d    = side_q;
    lvl_d     = lvl_q;
    ent_d     = ent_q;
    err_d     = err_q;
    tob_d     = tob_q;
    rdy_d     = rdy_q;
    upd_d     = 1'b0;
    tobp_d    = 1'b0;
    lerr_d    = 1'b0;

    if (side_q) begin
      cur = ask_q;
      n   = ask_cnt_q;
    end else begin
      cur = bid_q;
      n   = bid_cnt_q;
    end
    lm1   = int'(lvl_q) - 1;
    nb    = cur;
    nn    = n;
    legal = 1'b0;

    case (act_q)
      A_NEW: begin
        legal = (lvl_q != 8'd0) && (int'(lvl_q) <= int'(n) + 1) &&
                (int'(lvl_q) <= int'(DEPTH));
        // Shift L-1.. down one slot; the deepest level falls off
        for (int i = 1; i < int'(DEPTH); i++)
          if (i > lm1) nb[i] = cur[i-1];
        for (int i = 0; i < int'(DEPTH); i++)
          if (i == lm1) nb[i] = ent_q;
        nn = (int'(n) < int'(DEPTH)) ? n + CW'(1) : n;
      end
      A_CHG: begin
        legal = (lvl_q != 8'd0) && (int'(lvl_q) <= int'(n));
        for (int i = 0; i < int'(DEPTH); i++)
          if (i == lm1) nb[i] = ent_q;
      end
      A_DEL: begin
        legal = (lvl_q != 8'd0) && (int'(lvl_q) <= int'(n));
        // Shift L.. up one slot; the deepest level empties
        for (int i = 0; i < int'(DEPTH) - 1; i++)
          if (i >= lm1) nb[i] = cur[i+1];
        nb[DEPTH-1] = '0;
        nn = n - CW'(1);
      end
      default: begin
        legal = 1'b1;
        nb    = '{default: '0};
        nn    = '0;
      end
    endcase

    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (upd.message_ready && (upd.SECURITY_ID == SEC_ID) &&
            !upd.ENTRY_TYPE[1]) begin
          act_d   = upd.ACTION;
          side_d  = upd.ENTRY_TYPE[0];
          lvl_d   = upd.PRICE_LEVEL;
          ent_d   = {upd.PRICE, upd.QUANTITY, upd.NUM_ORDERS};
          rdy_d   = 1'b0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        err_d = !legal;
        tob_d = legal && (nb[0] != cur[0]);
        if (legal) begin
          if (side_q) begin
            ask_d     = nb;
            ask_cnt_d = nn;
          end else begin
            bid_d     = nb;
            bid_cnt_d = nn;
          end
        end
        state_d = PUBLISH;
      end
      PUBLISH: begin
        upd_d   = !err_q;
        tobp_d  = tob_q;
        lerr_d  = err_q;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bid_q     <= '{default: '0};
      ask_q     <= '{default: '0};
      bid_cnt_q <= '0;
      ask_cnt_q <= '0;
      act_q     <= '0;
      side_q    <= 1'b0;
      lvl_q     <= '0;
      ent_q     <= '0;
      err_q     <= 1'b0;
      tob_q     <= 1'b0;
      rdy_q     <= 1'b1;
      upd_q     <= 1'b0;
      tobp_q    <= 1'b0;
      lerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bid_q     <= bid_d;
      ask_q     <= ask_d;
      bid_cnt_q <= bid_cnt_d;
      ask_cnt_q <= ask_cnt_d;
      act_q     <= act_d;
      side_q    <= side_d;
      lvl_q     <= lvl_d;
      ent_q     <= ent_d;
      err_q     <= err_d;
      tob_q     <= tob_d;
      rdy_q     <= rdy_d;
      upd_q     <= upd_d;
      tobp_q    <= tobp_d;
      lerr_q    <= lerr_d;
    end
  end

  // Flatten the level arrays onto the output buses
  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_pack
    assign bid_book[g*LW +: LW] = bid_q[g];
    assign ask_book[g*LW +: LW] = ask_q[g];
  end

  assign upd.orderbook_ready = rdy_q;
  assign bid_count           = bid_cnt_q;
  assign ask_count           = ask_cnt_q;
  assign book_updated        = upd_q;
  assign tob_changed         = tobp_q;
  assign level_error         = lerr_q;

endmodule

// File: doc/mdp3_book_engine.md
Name: mdp3_book_engine

Overview:
Parametrised successor to the single-instrument Order_Book. It consumes decoded MDP3 market-by-price updates from MDP3_Parser and maintains DEPTH-level bid and ask books for one configured security. Adds explicit price-level addressing, insert/delete shifting, per-side occupancy counts, side-clear, error reporting and a top-of-book change strobe. It sits directly downstream of MDP3_Parser, and its outputs feed strategy/display logic.

Parameters:
SEC_ID, 123, security ID this instance tracks; other IDs are dropped.
DEPTH, 10, levels per side (2..32).
PRICE_W, 64, price field width.
QTY_W, 16, quantity field width.
NORD_W, 8, number-of-orders field width.
Derived: LW = PRICE_W+QTY_W+NORD_W (88 by default); CW = $clog2(DEPTH+1).

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
message_ready  in  1  parser has a valid update this cycle
SECURITY_ID  in  32  instrument of the update
ACTION  in  2  0=New, 1=Change, 2=Delete, 3=ClearSide
ENTRY_TYPE  in  2  0=bid, 1=ask, 2/3 ignored
PRICE_LEVEL  in  8  1-based target level
PRICE  in  PRICE_W  level price
QUANTITY  in  QTY_W  level quantity
NUM_ORDERS  in  NORD_W  level order count
orderbook_ready  out  1  engine can accept an update
bid_book  out  DEPTH*LW  level i (0 = best) at [i*LW +: LW], packed {price,qty,norders}
ask_book  out  DEPTH*LW  same packing, ask side
bid_count  out  CW  occupied bid levels
ask_count  out  CW  occupied ask levels
book_updated  out  1  one-cycle pulse after a book change
tob_changed  out  1  one-cycle pulse, with book_updated, when level 0 of either side changed
level_error  out  1  one-cycle pulse for an illegal level/action

Behaviour:
- Reset (reset_n=0 at a clk edge): all book entries 0; counts 0; orderbook_ready=1; all pulses 0; FSM→IDLE. Reset overrides any in-flight update, and that update is lost.
- FSM states: IDLE, APPLY, PUBLISH.
  - IDLE: orderbook_ready=1. Accept when message_ready=1, latching all inputs.
    - SECURITY_ID≠SEC_ID or ENTRY_TYPE∈{2,3}: drop silently, stay IDLE, no pulses.
    - Otherwise go to APPLY.
  - APPLY: orderbook_ready=0. Validate, then modify the selected side (L = PRICE_LEVEL, n = side count) → PUBLISH.
  - PUBLISH: orderbook_ready=0. Pulse book_updated or level_error, plus tob_changed if applicable → IDLE.
- Throughput: one update per 3 cycles; message_ready is ignored while orderbook_ready=0 (the parser must hold off).
- Latency: book_updated asserts 2 cycles after the accepting edge. Book outputs and counts are valid at the same edge.
- Validation (failure → level_error=1, book_updated=0, book unchanged):
  - New: 1≤L≤min(n+1,DEPTH).
  - Change, Delete: 1≤L≤n.
  - ClearSide: always legal; L ignored.
- New: entries L-1..DEPTH-2 shift down one slot; entry DEPTH-1 is discarded; new entry written at L-1. Count = min(n+1,DEPTH).
- Change: overwrite entry L-1. Count unchanged.
- Delete: entries L..DEPTH-1 shift up one slot; entry DEPTH-1 zeroed. Count = n-1.
- ClearSide: all entries of the side zeroed; count 0. Counts as an update.
- tob_changed: level-0 contents of the affected side differ before vs after APPLY.
- The opposite side is never modified. No crossed-book checking.
- Field widths: inputs are stored as-is. PRICE_LEVEL values above 255 are unrepresentable. Any L>DEPTH is illegal.

Test Plan:
- Reset, then New bid L=1 {P=0xAE, Q=9, N=1}, SECURITY_ID=123 → book_updated+tob_changed 2 cycles later; bid_book[0]={0xAE,9,1}; bid_count=1; ask side all 0.
- New bid L=1 {0xB0,5,2} after the above → level0={0xB0,5,2}, level1={0xAE,9,1}, bid_count=2. Then Delete L=1 → level0={0xAE,9,1}, level1=0, bid_count=1, tob_changed=1.
- Fill ask to DEPTH=10 with New L=n+1, then New L=1 → count stays 10, old level 9 discarded, old level 0 now at level 1. A following Change L=10 on ask updates level 9 only, tob_changed=0.
- Illegal cases: Change L=3 with bid_count=1, New L=0, Delete on an empty side → level_error pulse each time, no book_updated, books bit-identical before/after.
- SECURITY_ID=122 update, and ENTRY_TYPE=2 update → no pulses, orderbook_ready stays 1, books unchanged. ClearSide ask → ask_count=0, ask_book=0, bid unchanged.
- Hold message_ready=1 continuously with 3 distinct updates: only one is accepted per 3-cycle window, and only while orderbook_ready=1. Assert reset_n=0 during APPLY → next edge books/counts zero, no pulses, orderbook_ready=1.
